// File: rtl/obi_data_arbiter.sv
// ----------------------------------------------------------------------------
// obi_data_arbiter_pkg: OBI data-port payload types shared by the arbiter
// and its neighbours.
//
// obi_data_arbiter: merges NHARTS per-hart OBI data request ports onto one
// OBI manager port. A round-robin arbiter picks the winner, and a lock holds
// that winner until the bus grants it. An ID FIFO records the issuing hart of
// each outstanding transaction so that in-order responses are routed back.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   hart_req_i     per-hart requests (req, we, be, addr, wdata)
//   hart_resp_o    per-hart responses (gnt, rvalid, rdata), combinational
//   bus_req_o      merged request toward the system bus, combinational
//   bus_resp_i     system bus response
//   outstanding_o  current ID FIFO occupancy
//   err_o          sticky: rvalid seen while no transaction was outstanding
// ----------------------------------------------------------------------------
package obi_data_arbiter_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module obi_data_arbiter
   import obi_data_arbiter_pkg::*;
#(
   parameter int unsigned NHARTS          = 3,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  obi_req_t                               hart_req_i  [NHARTS],
   output obi_resp_t                              hart_resp_o [NHARTS],
   output obi_req_t                               bus_req_o,
   input  obi_resp_t                              bus_resp_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   err_o
);

   localparam int unsigned IDW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
   localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {
      ST_ARB,
      ST_LOCKED
   } state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  lock_id_q, lock_id_d;
   logic [IDW-1:0]  last_q, last_d;
   logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            err_q;

   logic            any_req;
   logic            found;
   logic [IDW-1:0]  sel;
   logic [IDW-1:0]  head;
   logic            can_issue;
   logic            valid_sel;
   logic            hs;
   logic            pop;
   int unsigned     idx;

   // Pointer increment with wrap at the FIFO depth.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (32'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + PW'(1);
   endfunction

   // Winner selection: a locked hart that still requests keeps the port,
   // otherwise round-robin starting after the last granted hart.
   always_comb begin
      any_req = 1'b0;
      found   = 1'b0;
      sel     = '0;
      idx     = 0;
      for (int unsigned i = 0; i < NHARTS; i++) begin
         any_req = any_req | hart_req_i[i].req;
      end
      for (int unsigned k = 1; k <= NHARTS; k++) begin
         idx = (32'(last_q) + k) % NHARTS;
         if (!found && hart_req_i[idx].req) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end
      end
      if (state_q == ST_LOCKED && hart_req_i[lock_id_q].req) begin
         sel = lock_id_q;
      end
   end

   assign can_issue = (count_q < CW'(MAX_OUTSTANDING));
   assign valid_sel = any_req & can_issue;
   assign bus_req_o = valid_sel ? hart_req_i[sel] : '0;
   assign hs        = bus_req_o.req & bus_resp_i.gnt;
   assign pop       = bus_resp_i.rvalid & (count_q != '0);
   assign head      = fifo_q[rd_ptr_q];

   // Grant goes to the selected hart only; response goes to the FIFO head.
   always_comb begin
      for (int unsigned i = 0; i < NHARTS; i++) begin
         hart_resp_o[i].gnt    = bus_resp_i.gnt & valid_sel & (sel == IDW'(i));
         hart_resp_o[i].rvalid = pop & (head == IDW'(i));
         hart_resp_o[i].rdata  = (pop && head == IDW'(i)) ? bus_resp_i.rdata : '0;
      end
   end

   // Lock/round-robin state: next-state logic.
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      last_d    = last_q;
      if (hs) begin
         state_d = ST_ARB;
         last_d  = sel;
      end else if (bus_req_o.req) begin
         // Presented but not granted: pin the winner so addr/data stay stable.
         state_d   = ST_LOCKED;
         lock_id_d = sel;
      end else if (state_q == ST_LOCKED && !hart_req_i[lock_id_q].req) begin
         state_d = ST_ARB;
      end
   end

   // Lock/round-robin state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_ARB;
         lock_id_q <= '0;
         last_q    <= IDW'(NHARTS - 1);
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         last_q    <= last_d;
      end
   end

   // Outstanding-ID FIFO, occupancy and sticky spurious-response flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (hs) begin
            fifo_q[wr_ptr_q] <= sel;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({hs, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (bus_resp_i.rvalid && count_q == '0) begin
            err_q <= 1'b1;
         end
      end
   end

   assign outstanding_o = count_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_obi_data_arbiter.sv
// ----------------------------------------------------------------------------
// Directed testbench for obi_data_arbiter (NHARTS=3, MAX_OUTSTANDING=2).
// Inputs change just after the falling edge; combinational outputs and state
// are sampled 1 ns later, well away from the rising (active) edge.
// ----------------------------------------------------------------------------
module tb_obi_data_arbiter;
   import obi_data_arbiter_pkg::*;

   localparam int unsigned NH = 3;

   logic       clk;
   logic       rst_i;
   obi_req_t   hreq  [NH];
   obi_resp_t  hresp [NH];
   obi_req_t   breq;
   obi_resp_t  bresp;
   logic [1:0] outst;
   logic       err;
   logic [2:0] gnt_vec;
   logic [2:0] rv_vec;

   int vectors;
   int errors;

   obi_data_arbiter #(.NHARTS(NH), .MAX_OUTSTANDING(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .hart_req_i   (hreq),
      .hart_resp_o  (hresp),
      .bus_req_o    (breq),
      .bus_resp_i   (bresp),
      .outstanding_o(outst),
      .err_o        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         gnt_vec[i] = hresp[i].gnt;
         rv_vec[i]  = hresp[i].rvalid;
      end
   end

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) hreq[i] = '0;
      bresp = '0;
   endtask

   task automatic set_req(input int h, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata);
      hreq[h].req   = 1'b1;
      hreq[h].we    = we;
      hreq[h].be    = 4'hF;
      hreq[h].addr  = addr;
      hreq[h].wdata = wdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      vectors++; if (breq !== '0) begin errors++; $display("FAIL rst_busreq: got %h exp 0", breq); end
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL rst_outst: got %0d exp 0", outst); end
      vectors++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
      vectors++; if (gnt_vec !== 3'b000 || rv_vec !== 3'b000) begin errors++; $display("FAIL rst_resp: gnt %b rv %b exp 000 000", gnt_vec, rv_vec); end
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   // Single read: same-cycle grant, response one cycle later.
   task automatic test_single_read();
      do_reset();
      @(negedge clk);
      set_req(0, 32'h0000_1000, 1'b0, 32'h0);
      bresp.gnt = 1'b1;
      #1;
      vectors++; if (gnt_vec !== 3'b001) begin errors++; $display("FAIL t1_gnt: got %b exp 001", gnt_vec); end
      vectors++; if (breq.addr !== 32'h0000_1000 || breq.req !== 1'b1) begin errors++; $display("FAIL t1_bus: got req %b addr %h exp 1 00001000", breq.req, breq.addr); end
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL t1_outst0: got %0d exp 0", outst); end
      @(negedge clk);
      clear_inputs();
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'hDEAD_BEEF;
      #1;
      vectors++; if (outst !== 2'd1) begin errors++; $display("FAIL t1_outst1: got %0d exp 1", outst); end
      vectors++; if (rv_vec !== 3'b001) begin errors++; $display("FAIL t1_rv: got %b exp 001", rv_vec); end
      vectors++; if (hresp[0].rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata: got %h exp deadbeef", hresp[0].rdata); end
      vectors++; if (gnt_vec !== 3'b000) begin errors++; $display("FAIL t1_gnt1: got %b exp 000", gnt_vec); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL t1_outst2: got %0d exp 0", outst); end
   endtask

   // All harts requesting, bus always granting: strict rotation 0,1,2,...
   task automatic test_round_robin();
      int eg;
      int pg;
      do_reset();
      @(negedge clk);
      for (int h = 0; h < 3; h++) set_req(h, 32'(h * 32'h100), 1'b0, 32'h0);
      bresp.gnt = 1'b1;
      for (int k = 0; k < 6; k++) begin
         eg = k % 3;
         pg = (k + 2) % 3;
         bresp.rvalid = (k > 0);
         bresp.rdata  = (k > 0) ? 32'hA000_0000 + 32'(k - 1) : 32'h0;
         #1;
         vectors++; if (gnt_vec !== 3'(1 << eg)) begin errors++; $display("FAIL t2_gnt%0d: got %b exp %b", k, gnt_vec, 3'(1 << eg)); end
         vectors++; if (breq.addr !== 32'(eg * 32'h100)) begin errors++; $display("FAIL t2_addr%0d: got %h exp %h", k, breq.addr, 32'(eg * 32'h100)); end
         if (k > 0) begin
            vectors++; if (rv_vec !== 3'(1 << pg)) begin errors++; $display("FAIL t2_rv%0d: got %b exp %b", k, rv_vec, 3'(1 << pg)); end
            vectors++; if (hresp[pg].rdata !== 32'hA000_0000 + 32'(k - 1)) begin errors++; $display("FAIL t2_rdata%0d: got %h exp %h", k, hresp[pg].rdata, 32'hA000_0000 + 32'(k - 1)); end
         end
         @(negedge clk);
      end
      clear_inputs();
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'hA000_0005;
      #1;
      vectors++; if (outst !== 2'd1) begin errors++; $display("FAIL t2_outst: got %0d exp 1", outst); end
      vectors++; if (rv_vec !== 3'b100 || hresp[2].rdata !== 32'hA000_0005) begin errors++; $display("FAIL t2_last: rv %b rdata %h exp 100 a0000005", rv_vec, hresp[2].rdata); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL t2_drain: got %0d exp 0", outst); end
   endtask

   // Lock holds hart1 through a stalled grant while hart0 has priority.
   task automatic test_lock();
      do_reset();
      @(negedge clk);
      set_req(1, 32'h20, 1'b1, 32'h1111_1111);
      #1;
      vectors++; if (breq.req !== 1'b1 || breq.addr !== 32'h20 || gnt_vec !== 3'b000) begin errors++; $display("FAIL t3_c0: req %b addr %h gnt %b exp 1 20 000", breq.req, breq.addr, gnt_vec); end
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         set_req(0, 32'h40, 1'b0, 32'h0);
         #1;
         vectors++; if (breq.addr !== 32'h20 || breq.wdata !== 32'h1111_1111 || gnt_vec !== 3'b000) begin errors++; $display("FAIL t3_c%0d: addr %h wdata %h gnt %b exp 20 11111111 000", c, breq.addr, breq.wdata, gnt_vec); end
      end
      @(negedge clk);
      bresp.gnt = 1'b1;
      #1;
      vectors++; if (breq.addr !== 32'h20 || gnt_vec !== 3'b010) begin errors++; $display("FAIL t3_c3: addr %h gnt %b exp 20 010", breq.addr, gnt_vec); end
      @(negedge clk);
      hreq[1] = '0;
      #1;
      vectors++; if (breq.addr !== 32'h40 || gnt_vec !== 3'b001) begin errors++; $display("FAIL t3_c4: addr %h gnt %b exp 40 001", breq.addr, gnt_vec); end
      vectors++; if (outst !== 2'd1) begin errors++; $display("FAIL t3_outst4: got %0d exp 1", outst); end
      @(negedge clk);
      clear_inputs();
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'h11;
      #1;
      vectors++; if (outst !== 2'd2 || rv_vec !== 3'b010) begin errors++; $display("FAIL t3_c5: outst %0d rv %b exp 2 010", outst, rv_vec); end
      @(negedge clk);
      bresp.rdata = 32'h22;
      #1;
      vectors++; if (rv_vec !== 3'b001 || hresp[0].rdata !== 32'h22) begin errors++; $display("FAIL t3_c6: rv %b rdata %h exp 001 22", rv_vec, hresp[0].rdata); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL t3_drain: got %0d exp 0", outst); end
   endtask

   // FIFO full blocks issue until a response frees a slot.
   task automatic test_fifo_full();
      do_reset();
      @(negedge clk);
      set_req(0, 32'h100, 1'b0, 32'h0);
      bresp.gnt = 1'b1;
      @(negedge clk);
      hreq[0] = '0;
      set_req(1, 32'h200, 1'b0, 32'h0);
      #1;
      vectors++; if (gnt_vec !== 3'b010) begin errors++; $display("FAIL t4_gnt1: got %b exp 010", gnt_vec); end
      @(negedge clk);
      hreq[1] = '0;
      set_req(2, 32'h300, 1'b0, 32'h0);
      #1;
      vectors++; if (outst !== 2'd2 || breq.req !== 1'b0 || gnt_vec !== 3'b000) begin errors++; $display("FAIL t4_full: outst %0d req %b gnt %b exp 2 0 000", outst, breq.req, gnt_vec); end
      @(negedge clk);
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'hAA;
      #1;
      vectors++; if (rv_vec !== 3'b001 || breq.req !== 1'b0 || gnt_vec !== 3'b000) begin errors++; $display("FAIL t4_pop: rv %b req %b gnt %b exp 001 0 000", rv_vec, breq.req, gnt_vec); end
      @(negedge clk);
      bresp.rvalid = 1'b0;
      #1;
      vectors++; if (outst !== 2'd1 || breq.req !== 1'b1 || breq.addr !== 32'h300 || gnt_vec !== 3'b100) begin errors++; $display("FAIL t4_issue: outst %0d req %b addr %h gnt %b exp 1 1 300 100", outst, breq.req, breq.addr, gnt_vec); end
      @(negedge clk);
      clear_inputs();
      bresp.rvalid = 1'b1;
      #1;
      vectors++; if (outst !== 2'd2 || rv_vec !== 3'b010) begin errors++; $display("FAIL t4_rv1: outst %0d rv %b exp 2 010", outst, rv_vec); end
      @(negedge clk);
      #1;
      vectors++; if (rv_vec !== 3'b100) begin errors++; $display("FAIL t4_rv2: got %b exp 100", rv_vec); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd0) begin errors++; $display("FAIL t4_drain: got %0d exp 0", outst); end
   endtask

   // Spurious response sets the sticky error; reset clears state at once.
   task automatic test_spurious_and_reset();
      do_reset();
      @(negedge clk);
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'hBAD;
      #1;
      vectors++; if (rv_vec !== 3'b000) begin errors++; $display("FAIL t5_norv: got %b exp 000", rv_vec); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (err !== 1'b1 || outst !== 2'd0) begin errors++; $display("FAIL t5_err: err %b outst %0d exp 1 0", err, outst); end
      @(negedge clk);
      set_req(0, 32'h500, 1'b0, 32'h0);
      bresp.gnt = 1'b1;
      #1;
      vectors++; if (gnt_vec !== 3'b001) begin errors++; $display("FAIL t5_gnt: got %b exp 001", gnt_vec); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd1 || err !== 1'b1) begin errors++; $display("FAIL t5_pre: outst %0d err %b exp 1 1", outst, err); end
      rst_i = 1'b1;
      #1;
      vectors++; if (err !== 1'b0 || outst !== 2'd0 || breq.req !== 1'b0) begin errors++; $display("FAIL t5_rst: err %b outst %0d req %b exp 0 0 0", err, outst, breq.req); end
      @(negedge clk);
      rst_i = 1'b0;
      bresp.rvalid = 1'b1;
      #1;
      vectors++; if (rv_vec !== 3'b000) begin errors++; $display("FAIL t5_dropped: got %b exp 000", rv_vec); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (err !== 1'b1) begin errors++; $display("FAIL t5_err2: got %b exp 1", err); end
   endtask

   // Push and pop in the same cycle keep occupancy and preserve order.
   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      set_req(0, 32'h600, 1'b0, 32'h0);
      bresp.gnt = 1'b1;
      @(negedge clk);
      hreq[0] = '0;
      set_req(2, 32'h700, 1'b0, 32'h0);
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'h55;
      #1;
      vectors++; if (gnt_vec !== 3'b100 || rv_vec !== 3'b001) begin errors++; $display("FAIL t6_both: gnt %b rv %b exp 100 001", gnt_vec, rv_vec); end
      vectors++; if (hresp[0].rdata !== 32'h55 || hresp[2].rdata !== 32'h0) begin errors++; $display("FAIL t6_rdata: h0 %h h2 %h exp 55 0", hresp[0].rdata, hresp[2].rdata); end
      @(negedge clk);
      clear_inputs();
      bresp.rvalid = 1'b1;
      bresp.rdata  = 32'h66;
      #1;
      vectors++; if (outst !== 2'd1) begin errors++; $display("FAIL t6_outst: got %0d exp 1", outst); end
      vectors++; if (rv_vec !== 3'b100 || hresp[2].rdata !== 32'h66) begin errors++; $display("FAIL t6_rv2: rv %b rdata %h exp 100 66", rv_vec, hresp[2].rdata); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++; if (outst !== 2'd0 || err !== 1'b0) begin errors++; $display("FAIL t6_drain: outst %0d err %b exp 0 0", outst, err); end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_fifo_full();
      test_spurious_and_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within 100000 ns");
      $fatal(1);
   end

endmodule

// File: doc/obi_data_arbiter.md
Name: obi_data_arbiter

Overview:
- Downstream stage of the triple-core CPU system. Merges the NHARTS per-hart OBI data request ports into a single OBI manager port toward the system bus.
- Arbitrates round-robin and locks the winner until the bus grants it.
- Tracks outstanding transactions in an ID FIFO so each response (rvalid/rdata) returns to the hart that issued the request.

Parameters:
- NHARTS, 3, number of hart request ports (>=2).
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (>=1); counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- hart_req_i  input  obi_req_t[NHARTS]  per-hart data requests (req, we, be[3:0], addr[31:0], wdata[31:0]).
- hart_resp_o  output  obi_resp_t[NHARTS]  per-hart responses (gnt, rvalid, rdata[31:0]).
- bus_req_o  output  obi_req_t  merged request to system bus.
- bus_resp_i  input  obi_resp_t  system bus response.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_o  output  1  sticky: rvalid received with FIFO empty.

Behaviour:
- Reset (rst_i high, async): FIFO empty, count=0, rd/wr pointers=0, lock_q=0, last_q=NHARTS-1 (hart 0 highest priority), err_o=0. All outputs are derived from this state, so after reset bus_req_o='0 and all hart_resp_o gnt/rvalid=0. Reset mid-transaction drops all outstanding IDs; later rvalids with an empty FIFO set err_o.
- Issue enable: can_issue = (count < MAX_OUTSTANDING). No issue in a cycle where the FIFO is full, even if rvalid pops in that cycle.
- Selection (combinational):
  - If lock_q=1 and hart_req_i[lock_id_q].req=1, sel = lock_id_q.
  - Otherwise sel = the first requesting hart, searching from (last_q+1) mod NHARTS upward with wrap.
  - valid_sel = (some hart requesting) AND can_issue.
- bus_req_o:
  - valid_sel=1: all fields of hart_req_i[sel].
  - valid_sel=0: all fields '0.
- Grant routing: hart_resp_o[sel].gnt = bus_resp_i.gnt AND valid_sel. All other gnt=0. Zero-cycle combinational path.
- Handshake: hs = bus_req_o.req AND bus_resp_i.gnt. On hs:
  - push sel into FIFO at wr_ptr;
  - last_q <= sel;
  - lock_q <= 0.
- Lock:
  - bus_req_o.req=1 and gnt=0: lock_q <= 1, lock_id_q <= sel. Bus address and data stay stable until grant.
  - Locked hart deasserts req (protocol violation): lock_q <= 0 and re-arbitrate that same cycle.
  - FIFO-full while locked: bus req drops; the lock is held.
- Response: on bus_resp_i.rvalid with count>0:
  - hart_resp_o[head].rvalid=1 and hart_resp_o[head].rdata=bus_resp_i.rdata, combinational with zero latency;
  - pop, rd_ptr advances.
  - Other harts get rvalid=0, rdata='0.
- Spurious response: rvalid with count=0 sets err_o to 1 until reset, with no pop and no rvalid to any hart.
- Simultaneous push and pop: count unchanged, both pointers advance. Response order equals grant order (OBI in-order).
- Pointer wrap: pointers wrap modulo MAX_OUTSTANDING.
- Protocol limit: at most one grant per cycle.

Test Plan:
1. Hart0 read addr 0x0000_1000, bus gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> hart0 gnt in cycle 0, rvalid+0xDEADBEEF in cycle 1; harts 1/2 see no gnt/rvalid; outstanding_o 0->1->0.
2. All three harts hold req, bus gnt always 1, rvalid 1 cycle later -> grant order 0,1,2,0,1,2; each rvalid goes to the matching hart with its distinct rdata.
3. Hart1 requests addr 0x20, bus gnt low 3 cycles, hart0 raises req in cycle 1 -> bus_req_o.addr stays 0x20 for 4 cycles; hart1 granted in cycle 3; hart0 issued in cycle 4.
4. MAX_OUTSTANDING=2, two grants, no rvalid, hart2 requesting -> outstanding_o=2, bus_req_o.req=0. After one rvalid, hart2 issues the next cycle.
5. rvalid with FIFO empty -> err_o=1, no hart rvalid. Assert rst_i for 1 cycle while outstanding_o=1 -> err_o=0, outstanding_o=0, bus_req_o.req=0 immediately.
6. gnt for hart2 and rvalid for hart0 in the same cycle at count=1 -> count stays 1; next rvalid routed to hart2.
